// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle RV32I controller
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LINK,
        S_UPPER,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch condition evaluation from funct3 and ALU flags of rs1-rs2
module branch_unit
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       neg,
    input  logic       ovf,
    input  logic       carry,
    output logic       taken,
    output logic       illegal_funct3
);

    always_comb begin
        taken          = 1'b0;
        illegal_funct3 = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BLT:  taken = neg ^ ovf;
            F3_BGE:  taken = !(neg ^ ovf);
            // carry set means no borrow, i.e. rs1 >= rs2 unsigned
            F3_BLTU: taken = !carry;
            F3_BGEU: taken = carry;
            default: illegal_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with memory handshake and trap
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 4,
    parameter int MEM_TMO  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                Zero,
    input  logic                Neg,
    input  logic                Ovf,
    input  logic                Carry,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                MemWrite,
    output logic                AdrSrc,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                RegWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ImmSrc,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                illegal,
    output logic                retire
);

    localparam int TMO_W = (MEM_TMO > 0) ? $clog2(MEM_TMO + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TMO > 0) ? MEM_TMO - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;

    state_t           state_q, state_d;
    logic             active_q, active_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             taken, bad_f3;
    logic             waiting, tmo_hit;
    logic [3:0]       alu_op, alu_sel;

    branch_unit u_branch (
        .funct3         (funct3),
        .zero           (Zero),
        .neg            (Neg),
        .ovf            (Ovf),
        .carry          (Carry),
        .taken          (taken),
        .illegal_funct3 (bad_f3)
    );

    // SUB only exists for R-type; funct7b5 on funct3=101 selects SRA for both R and I
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (state_q == S_EXEC_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    // active_q holds every output low from reset until the first clock after release
    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ImmSrc    = IMM_I;
        alu_sel   = ALU_ADD;
        illegal   = 1'b0;
        retire    = 1'b0;
        if (active_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = RES_MEMDATA;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                    retire   = mem_ready;
                end
                S_EXEC_R: begin
                    ALUSrcA = SRCA_RS1;
                    alu_sel = alu_op;
                end
                S_EXEC_I: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    alu_sel = alu_op;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = SRCA_RS1;
                    alu_sel = ALU_SUB;
                    PCWrite = taken && !bad_f3;
                    retire  = !bad_f3;
                end
                S_JAL: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = 1'b1;
                end
                S_JALR: begin
                    ALUSrcA   = SRCA_RS1;
                    ALUSrcB   = SRCB_IMM;
                    ResultSrc = RES_ALU;
                    PCWrite   = 1'b1;
                end
                S_LINK: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                end
                S_UPPER: begin
                    ALUSrcA = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_U;
                end
                S_TRAP:  illegal = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
    end

    assign ALUControl = ALUCTL_W'(alu_sel);

    always_comb begin
        active_d = 1'b1;
        waiting  = mem_req && !mem_ready;
        tmo_hit  = (MEM_TMO > 0) && waiting && (tmo_q == TMO_LAST);
        state_d  = state_q;
        if (active_q) begin
            case (state_q)
                S_FETCH:  if (mem_ready) state_d = S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXEC_R;
                        OP_I:              state_d = S_EXEC_I;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR;
                        OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                        default:           state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
                S_MEMWR:  if (mem_ready) state_d = S_FETCH;
                S_MEMWB, S_ALUWB: state_d = S_FETCH;
                S_EXEC_R, S_EXEC_I, S_JAL, S_LINK, S_UPPER: state_d = S_ALUWB;
                S_BRANCH: state_d = bad_f3 ? S_TRAP : S_FETCH;
                S_JALR:   state_d = S_LINK;
                default:  state_d = S_TRAP;
            endcase
            if (tmo_hit) state_d = S_TRAP;
        end
        tmo_d = '0;
        if (waiting && state_d == state_q) tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            active_q <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0, Neg = 1'b0, Ovf = 1'b0, Carry = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal, retire;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    logic       t_mem_req, t_MemWrite, t_AdrSrc, t_IRWrite, t_PCWrite, t_RegWrite, t_illegal, t_retire;
    logic [1:0] t_ResultSrc, t_ALUSrcA, t_ALUSrcB;
    logic [2:0] t_ImmSrc;
    logic [3:0] t_ALUControl;

    localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, RTYPE = 7'h33, ITYPE = 7'h13;
    localparam logic [6:0] BRANCH = 7'h63, JALR = 7'h67, LUI = 7'h37;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    multicycle_controller #(.ALUCTL_W(4), .MEM_TMO(0)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Neg(Neg), .Ovf(Ovf), .Carry(Carry), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal),
        .retire(retire)
    );

    multicycle_controller #(.ALUCTL_W(4), .MEM_TMO(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Neg(Neg), .Ovf(Ovf), .Carry(Carry), .mem_ready(mem_ready),
        .mem_req(t_mem_req), .MemWrite(t_MemWrite), .AdrSrc(t_AdrSrc), .IRWrite(t_IRWrite),
        .PCWrite(t_PCWrite), .RegWrite(t_RegWrite), .ResultSrc(t_ResultSrc), .ALUSrcA(t_ALUSrcA),
        .ALUSrcB(t_ALUSrcB), .ImmSrc(t_ImmSrc), .ALUControl(t_ALUControl), .illegal(t_illegal),
        .retire(t_retire)
    );

    wire [20:0] ctl   = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
                         ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, retire};
    wire [20:0] t_ctl = {t_mem_req, t_MemWrite, t_AdrSrc, t_IRWrite, t_PCWrite, t_RegWrite, t_ResultSrc,
                         t_ALUSrcA, t_ALUSrcB, t_ImmSrc, t_ALUControl, t_illegal, t_retire};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic f7, input string tag);
        next_cycle(1'b1);
        opcode = op;
        funct3 = f3;
        funct7b5 = f7;
        #1;
        start_cyc = cyc;
        chk({tag, "_fetch_req"}, {mem_req, AdrSrc}, 2'b10);
        chk({tag, "_fetch_ir_pc"}, {IRWrite, PCWrite, ResultSrc, ALUSrcB}, 6'b11_10_10);
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [3:0] exp_alu, input string tag);
        fetch(op, f3, f7, tag);
        next_cycle(1'b0);
        chk({tag, "_decode_regwrite"}, {RegWrite, retire}, 2'b00);
        next_cycle(1'b0);
        chk({tag, "_exec_alu"}, ALUControl, exp_alu);
        chk({tag, "_exec_srca"}, ALUSrcA, 2'b10);
        chk({tag, "_exec_regwrite"}, RegWrite, 1'b0);
        next_cycle(1'b0);
        chk({tag, "_wb_regwrite_retire"}, {RegWrite, retire, ResultSrc}, 4'b1100);
        chk({tag, "_cycles"}, cyc - start_cyc + 1, 4);
    endtask

    task automatic run_branch(input logic [2:0] f3, input logic z, input logic n, input logic v,
                              input logic c, input logic exp_taken, input string tag);
        fetch(BRANCH, f3, 1'b0, tag);
        Zero = z; Neg = n; Ovf = v; Carry = c;
        next_cycle(1'b0);
        chk({tag, "_decode_imm"}, ImmSrc, 3'b010);
        next_cycle(1'b0);
        chk({tag, "_pcwrite"}, PCWrite, exp_taken);
        chk({tag, "_retire_alu"}, {retire, ALUControl, ResultSrc}, 7'b1_0001_00);
        next_cycle(1'b0);
        chk({tag, "_back_to_fetch"}, mem_req, 1'b1);
        chk({tag, "_cycles"}, cyc - start_cyc, 3);
    endtask

    initial begin
        #12;
        chk("reset_outputs", ctl, 21'd0);
        chk("reset_outputs_tmo", t_ctl, 21'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Timeout: ready stuck low in fetch
        for (int i = 1; i <= 4; i++) begin
            next_cycle(1'b0);
            chk($sformatf("tmo_wait_%0d", i), {t_illegal, t_mem_req}, 2'b01);
        end
        next_cycle(1'b0);
        chk("tmo_trapped", {t_illegal, t_mem_req}, 2'b10);
        chk("no_tmo_still_waiting", {illegal, mem_req}, 2'b01);

        do_reset();
        run_alu(RTYPE, 3'b000, 1'b0, 4'd0, "add");
        next_cycle(1'b0);
        chk("after_add_fetch", {mem_req, RegWrite, retire, IRWrite}, 4'b1000);
        run_alu(RTYPE, 3'b000, 1'b1, 4'd1, "sub");
        run_alu(ITYPE, 3'b000, 1'b1, 4'd0, "addi_f7");
        run_alu(ITYPE, 3'b101, 1'b1, 4'd9, "srai");
        run_alu(RTYPE, 3'b110, 1'b0, 4'd3, "or");

        // Load with three wait cycles
        fetch(LOAD, 3'b010, 1'b0, "lw");
        next_cycle(1'b0);
        next_cycle(1'b0);
        chk("lw_memadr", {mem_req, ALUSrcA, ALUSrcB, ImmSrc}, 8'b0_10_01_000);
        for (int i = 0; i < 3; i++) begin
            next_cycle(1'b0);
            chk($sformatf("lw_wait_%0d", i), {mem_req, AdrSrc, RegWrite, retire}, 4'b1100);
        end
        next_cycle(1'b1);
        chk("lw_memrd_ready", {mem_req, AdrSrc, retire}, 3'b110);
        next_cycle(1'b0);
        chk("lw_memwb", {ResultSrc, RegWrite, retire}, 4'b01_1_1);
        chk("lw_cycles", cyc - start_cyc + 1, 8);
        next_cycle(1'b0);
        chk("lw_next_fetch", {mem_req, AdrSrc, RegWrite}, 3'b100);

        // Store, ready immediately
        fetch(STORE, 3'b010, 1'b0, "sw");
        next_cycle(1'b0);
        next_cycle(1'b0);
        chk("sw_memadr_imm", ImmSrc, 3'b001);
        next_cycle(1'b1);
        chk("sw_memwr", {mem_req, MemWrite, AdrSrc, retire, RegWrite}, 5'b11110);
        chk("sw_cycles", cyc - start_cyc + 1, 4);

        // Store interrupted by reset while waiting
        fetch(STORE, 3'b010, 1'b0, "sw_rst");
        next_cycle(1'b0);
        next_cycle(1'b0);
        next_cycle(1'b0);
        chk("sw_rst_waiting", {mem_req, MemWrite, retire}, 3'b110);
        rst_n = 1'b0;
        #1;
        chk("sw_rst_async_drop", {mem_req, MemWrite}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle(1'b0);
        chk("sw_rst_restart_fetch", {mem_req, MemWrite, AdrSrc, illegal}, 4'b1000);

        run_branch(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "blt_taken");
        run_branch(3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "bltu_not");
        run_branch(3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "bge_taken");
        run_branch(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "bne_not");

        // JALR: target, link prep, writeback
        fetch(JALR, 3'b000, 1'b0, "jalr");
        next_cycle(1'b0);
        next_cycle(1'b0);
        chk("jalr_target", {PCWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite}, 8'b1_10_10_01_0);
        next_cycle(1'b0);
        chk("jalr_link", {PCWrite, ALUSrcA, ALUSrcB, RegWrite}, 6'b0_01_10_0);
        next_cycle(1'b0);
        chk("jalr_wb", {RegWrite, retire}, 2'b11);
        chk("jalr_cycles", cyc - start_cyc + 1, 5);

        fetch(LUI, 3'b000, 1'b0, "lui");
        next_cycle(1'b0);
        next_cycle(1'b0);
        chk("lui_upper", {ALUSrcA, ALUSrcB, ImmSrc, ALUControl}, 11'b11_01_100_0000);
        next_cycle(1'b0);
        chk("lui_wb", {RegWrite, retire}, 2'b11);

        // Branch with reserved funct3 traps
        fetch(BRANCH, 3'b010, 1'b0, "bad_br");
        next_cycle(1'b0);
        next_cycle(1'b0);
        chk("bad_br_no_retire", {PCWrite, retire, illegal}, 3'b000);
        next_cycle(1'b0);
        chk("bad_br_trap", {illegal, mem_req}, 2'b10);

        // Unknown opcode traps and stays trapped
        do_reset();
        fetch(7'h7F, 3'b000, 1'b0, "op7f");
        next_cycle(1'b1);
        chk("op7f_decode", illegal, 1'b0);
        for (int i = 0; i < 3; i++) begin
            next_cycle(1'b1);
            chk($sformatf("op7f_trap_%0d", i), {illegal, PCWrite, RegWrite, mem_req, IRWrite}, 5'b10000);
        end
        do_reset();
        next_cycle(1'b0);
        chk("op7f_reset_clears", {illegal, mem_req}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
